// File: rtl/eeprom_rw_seq_pkg.sv
// Shared types and widths for the EEPROM read/write sequencer.
package eeprom_seq_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_GAP,
    WR_REQ,
    WR_WAIT,
    RD_GAP,
    RD_REQ,
    RD_WAIT,
    DISP
  } state_e;

  // Counter width able to hold 0..max_val inclusive, never zero bits wide.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return $clog2(max_val + 2);
  endfunction

endpackage

// File: rtl/eeprom_rw_seq_if.sv
// Handshake and byte bus between the sequencer and the I2C byte controller.
interface eeprom_rw_seq_if;
  import eeprom_seq_pkg::*;

  logic              i2c_start;
  logic              i2c_end;
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] byte_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output i2c_start, wr_en, rd_en, byte_addr, wr_data,
    input  i2c_end, rd_data
  );

  modport slave (
    input  i2c_start, wr_en, rd_en, byte_addr, wr_data,
    output i2c_end, rd_data
  );

endinterface

// File: rtl/eeprom_rw_seq_sync_fifo.sv
// Single-clock FIFO with a registered read port; reset empties it and clears rdata.
module sync_fifo #(
  parameter int unsigned DATA_W = eeprom_seq_pkg::DATA_W,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = rdata_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (push && !full) wptr_d = wptr_q + (AW+1)'(1);
    if (pop) begin
      rptr_d  = rptr_q + (AW+1)'(1);
      rdata_d = mem[rptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr_q[AW-1:0]] <= wdata;
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/eeprom_rw_seq.sv
// Sequencer: write burst of DATA_NUM bytes, or read burst into a FIFO then slow
// one-byte-at-a-time display. All handshake outputs are registered.
module eeprom_rw_seq
  import eeprom_seq_pkg::*;
#(
  parameter int unsigned       DATA_NUM     = 10,
  parameter int unsigned       FIFO_DEPTH   = 16,
  parameter logic [ADDR_W-1:0] START_ADDR   = 16'h005A,
  parameter logic [DATA_W-1:0] WR_INIT      = 8'hA5,
  parameter int unsigned       GAP_MAX      = 249_999,
  parameter int unsigned       DISP_CNT_MAX = 49_999_999
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   write,
  input  logic                   read,
  eeprom_rw_seq_if.master        bus,
  output logic [DATA_W-1:0]      fifo_data,
  output logic                   busy
);

  localparam int unsigned GAP_W  = cnt_w(GAP_MAX);
  localparam int unsigned DISP_W = cnt_w(DISP_CNT_MAX);
  localparam int unsigned IDX_W  = cnt_w(DATA_NUM);

  state_e            state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              start_q, start_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              push, pop, fifo_full, fifo_empty;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.rd_data),
    .rdata (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    disp_d  = disp_q;
    idx_d   = idx_q;
    wr_en_d = wr_en_q;
    rd_en_d = rd_en_q;
    start_d = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (write) begin
          state_d = WR_GAP;
          wr_en_d = 1'b1;
          idx_d   = '0;
          gap_d   = '0;
        end else if (read) begin
          state_d = RD_GAP;
          rd_en_d = 1'b1;
          idx_d   = '0;
          gap_d   = '0;
        end
      end
      WR_GAP, RD_GAP: begin
        if (gap_q == GAP_W'(GAP_MAX)) begin
          gap_d   = '0;
          state_d = (state_q == WR_GAP) ? WR_REQ : RD_REQ;
          start_d = 1'b1;
          addr_d  = START_ADDR + ADDR_W'(idx_q);
          wdata_d = WR_INIT + DATA_W'(idx_q);
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      WR_REQ: state_d = WR_WAIT;
      RD_REQ: state_d = RD_WAIT;
      WR_WAIT, RD_WAIT: begin
        if (bus.i2c_end) begin
          push = (state_q == RD_WAIT) && !fifo_full;
          if (idx_q == IDX_W'(DATA_NUM - 1)) begin
            if (state_q == WR_WAIT) begin
              state_d = IDLE;
              wr_en_d = 1'b0;
            end else begin
              state_d = DISP;
              rd_en_d = 1'b0;
              disp_d  = '0;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = (state_q == WR_WAIT) ? WR_GAP : RD_GAP;
          end
        end
      end
      DISP: begin
        // Pop at the start of each hold period; leave once the last period ends empty.
        pop = (disp_q == '0);
        if (disp_q == DISP_W'(DISP_CNT_MAX)) begin
          disp_d = '0;
          if (fifo_empty) state_d = IDLE;
        end else begin
          disp_d = disp_q + DISP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      disp_q  <= '0;
      idx_q   <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      disp_q  <= disp_d;
      idx_q   <= idx_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.i2c_start = start_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.byte_addr = addr_q;
  assign bus.wr_data   = wdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/eeprom_rw_seq.md
Name: eeprom_rw_seq

Overview:
Transaction sequencer that sits directly upstream of the I2C byte controller in the EEPROM demo and downstream of the two key debouncers. A write pulse issues a burst of DATA_NUM single-byte EEPROM writes at consecutive addresses. A read pulse reads the same bytes back into an internal FIFO and then presents them one at a time, at a slow rate, on fifo_data for the 7-segment display driver. Runs entirely on sys_clk and handshakes with the controller via i2c_start and i2c_end.

Parameters:
DATA_NUM, 10, bytes per burst (1..FIFO_DEPTH)
FIFO_DEPTH, 16, internal read-FIFO depth, power of 2
START_ADDR, 16'h005A, EEPROM address of the first byte
WR_INIT, 8'hA5, data of the first byte; byte i carries WR_INIT+i
GAP_MAX, 249_999, idle cycles minus 1 before each transaction (5 ms at 50 MHz, covers EEPROM tWR)
DISP_CNT_MAX, 49_999_999, display hold time minus 1 per byte (1 s)

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
write  in  1  one-cycle pulse from write-key debouncer
read  in  1  one-cycle pulse from read-key debouncer
i2c_end  in  1  one-cycle pulse from controller: current byte transaction finished
rd_data  in  8  byte read by controller, valid in the i2c_end cycle
i2c_start  out  1  one-cycle pulse requesting one transaction
wr_en  out  1  level, high for the whole write burst
rd_en  out  1  level, high for the whole read burst
byte_addr  out  16  EEPROM address of the current transaction
wr_data  out  8  data for the current write
fifo_data  out  8  byte currently shown on the display
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; FIFO emptied. Reset mid-burst aborts immediately with no further i2c_start.
- States: IDLE, WR_GAP, WR_REQ, WR_WAIT, RD_GAP, RD_REQ, RD_WAIT, DISP.
- IDLE: write pulse -> WR_GAP with wr_en=1 and idx=0. Otherwise a read pulse -> RD_GAP with rd_en=1 and idx=0. If write and read arrive in the same cycle, write wins. Both pulses are ignored in every non-IDLE state.
- xx_GAP: gap_cnt counts 0..GAP_MAX, then the FSM moves to xx_REQ. Every transaction, including the first, waits GAP_MAX+1 cycles.
- xx_REQ: i2c_start=1 for exactly one cycle. byte_addr=START_ADDR+idx (16-bit modulo, 16'hFFFF wraps to 0). wr_data=WR_INIT+idx (8-bit modulo). Next state xx_WAIT.
- byte_addr and wr_data are registered and stable from xx_REQ until the next xx_REQ.
- xx_WAIT: hold until i2c_end. In RD_WAIT, rd_data is pushed into the FIFO on the i2c_end cycle.
- On i2c_end with idx<DATA_NUM-1: idx++ and return to xx_GAP.
- On i2c_end after the last write: go to IDLE and clear wr_en on the next cycle.
- On i2c_end after the last read: go to DISP and clear rd_en.
- i2c_end outside xx_WAIT is ignored.
- DISP pop timing: the first pop happens in the first DISP cycle; subsequent pops every DISP_CNT_MAX+1 cycles. fifo_data takes the popped byte one cycle after the pop.
- DISP exit: after the last byte's full hold period, with the FIFO empty, return to IDLE. fifo_data keeps the last byte until the next DISP pop or reset.
- FIFO never overflows (DATA_NUM<=FIFO_DEPTH). A pop on empty is impossible by construction; an assertion flags it.
- busy = (state != IDLE).

Decomposition:
- Shared package eeprom_seq_pkg: state enum, width constant ADDR_W=16, DATA_W=8.
- One sub-module, sync_fifo: single-clock FIFO (DATA_W, DEPTH) with push, pop, full, empty and a registered read output.
- FSM, counters and address/data generation live in eeprom_rw_seq.

Test Plan:
Bench parameters for all scenarios: DATA_NUM=4, GAP_MAX=9, DISP_CNT_MAX=19. The controller model returns i2c_end 30 cycles after i2c_start, with rd_data = 8'h10+addr[7:0].
- Write burst: one write pulse -> 4 i2c_start pulses, each 10 cycles after IDLE exit or the previous i2c_end. Addresses 005A..005D, data A5..A8, wr_en high throughout. IDLE and busy=0 one cycle after the 4th i2c_end.
- Read and display: one read pulse -> 4 reads of 005A..005D with rd_en high. Then fifo_data shows 6A, 6B, 6C, 6D, each held 20 cycles. Then IDLE with fifo_data=6D.
- Simultaneous and ignored pulses: write and read in the same cycle -> write burst only. A read pulse during the write burst -> no effect; the burst ends with exactly 4 i2c_start pulses.
- Address wrap: START_ADDR=16'hFFFE, WR_INIT=8'hFE -> addresses FFFE, FFFF, 0000, 0001 with data FE, FF, 00, 01.
- Reset mid-operation: sys_rst asserted in RD_WAIT after 2 bytes -> next cycle all outputs 0 and FIFO empty. A later read burst displays only its own 4 bytes.
- Spurious i2c_end in IDLE or xx_GAP: ignored; no state change, no FIFO push.
